// File: rtl/sobel_pkg.sv
// Shared definitions for the image transmit path: frame FSM encoding,
// 8N1 frame length and a counter-width helper.
package sobel_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StCarrega = 3'd1,
      StEnvia   = 3'd2,
      StAvanca  = 3'd3,
      StEspera  = 3'd4,
      StFim     = 3'd5
   } tx_state_e;

   // Start bit + 8 data bits + stop bit.
   localparam int unsigned UartFrameBits = 10;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_serial.sv
// 8N1 UART serializer: loads a byte on partida, shifts it out LSB first and
// flags pronto during the final cycle of the stop bit.
module uart_tx_serial
   import sobel_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [7:0] dado,
   output logic       serial_out,
   output logic       pronto
);

   localparam int unsigned BaudW = cnt_width(CLKS_PER_BIT);
   localparam int unsigned BitW  = cnt_width(UartFrameBits);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(UartFrameBits - 1);

   logic             busy_q, busy_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [BitW-1:0]  bit_q, bit_d;
   logic [8:0]       shift_q, shift_d;
   logic             line_q, line_d;
   logic             bit_end;

   assign bit_end    = busy_q && (baud_q == BaudLast);
   assign serial_out = line_q;

   always_comb begin
      busy_d  = busy_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      line_d  = line_q;
      // Combinational so the frame FSM leaves ENVIA on the last stop-bit cycle.
      pronto  = bit_end && (bit_q == BitLast);

      if (!busy_q) begin
         if (partida) begin
            busy_d  = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
            // Data bits followed by the stop bit; the start bit goes out now.
            shift_d = {1'b1, dado};
            line_d  = 1'b0;
         end
      end else if (bit_end) begin
         baud_d = '0;
         if (bit_q == BitLast) begin
            busy_d = 1'b0;
            line_d = 1'b1;
         end else begin
            line_d  = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bit_d   = bit_q + 1'b1;
         end
      end else begin
         baud_d = baud_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q  <= 1'b0;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         line_q  <= 1'b1;
      end else begin
         busy_q  <= busy_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         line_q  <= line_d;
      end
   end

endmodule

// File: rtl/image_tx_streamer.sv
// Streams one WIDTH*HEIGHT framebuffer over UART 8N1 per iniciar request,
// pacing framebuffer reads with tx_pronto.
module image_tx_streamer
   import sobel_pkg::*;
#(
   parameter int unsigned WIDTH        = 160,
   parameter int unsigned HEIGHT       = 120,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [7:0] pixel_in,
   output logic       tx_pronto,
   output logic       serial_out,
   output logic       ocupado,
   output logic       fim_transmissao
);

   localparam int unsigned NumPixels = WIDTH * HEIGHT;
   localparam int unsigned PixW      = cnt_width(NumPixels);
   localparam logic [PixW-1:0] PixLast = PixW'(NumPixels - 1);

   tx_state_e       state_q, state_d;
   logic [PixW-1:0] pix_cnt_q, pix_cnt_d;
   logic            partida;
   logic            pronto;

   uart_tx_serial #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_serial (
      .clock     (clock),
      .reset     (reset),
      .partida   (partida),
      .dado      (pixel_in),
      .serial_out(serial_out),
      .pronto    (pronto)
   );

   assign ocupado = (state_q != StIdle);

   always_comb begin
      state_d         = state_q;
      pix_cnt_d       = pix_cnt_q;
      partida         = 1'b0;
      tx_pronto       = 1'b0;
      fim_transmissao = 1'b0;

      case (state_q)
         StIdle: begin
            if (iniciar) begin
               state_d   = StCarrega;
               pix_cnt_d = '0;
            end
         end
         StCarrega: begin
            partida = 1'b1;
            state_d = StEnvia;
         end
         StEnvia: begin
            if (pronto) state_d = StAvanca;
         end
         StAvanca: begin
            tx_pronto = 1'b1;
            // Last pixel leaves the counter alone; FIM clears it.
            if (pix_cnt_q == PixLast) begin
               state_d = StFim;
            end else begin
               pix_cnt_d = pix_cnt_q + 1'b1;
               state_d   = StEspera;
            end
         end
         StEspera: begin
            state_d = StCarrega;
         end
         StFim: begin
            fim_transmissao = 1'b1;
            pix_cnt_d       = '0;
            state_d         = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         pix_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
      end
   end

endmodule
